regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the register file's single write port between the ALU writeback stage and the LDR writeback stage. LDR writes always win the port. ALU writes that lose arbitration are parked in a small in-order pending buffer and retired on later free cycles. The block sits between the writeback-stage controllers and the register file. It raises `sel_stall` to the pipeline when an ALU write can neither retire nor be parked, and exposes a forwarding lookup so operand reads can see parked values.

## Interface
- `DEPTH`, 2: pending-buffer entries; power of two, ≥2
- `ADDR_W`, 4: register address width
- `DATA_W`, 32: register data width

Ports:
- `clk` in 1: the single clock; everything is on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `w_en_ldr` in 1: LDR writeback request
- `ldr_addr` in ADDR_W: LDR destination register
- `ldr_data` in DATA_W: LDR loaded value
- `w_en_alu` in 1: ALU writeback request
- `alu_addr` in ADDR_W: ALU destination register
- `alu_data` in DATA_W: ALU result
- `rf_w_en` out 1: register file write enable; registered
- `rf_w_addr` out ADDR_W: register file write address; registered
- `rf_w_data` out DATA_W: register file write data; registered
- `sel_stall` out 1: ALU request not accepted this cycle; upstream holds it; combinational
- `fwd_addr` in ADDR_W: operand address for the forwarding lookup
- `fwd_hit` out 1: a parked entry matches `fwd_addr`; combinational
- `fwd_data` out DATA_W: data of the newest matching parked entry; combinational
- `pending_count` out clog2(DEPTH)+1: number of occupied buffer entries

## Operation
- Port selection each cycle, in strict priority:
  1. `w_en_ldr` → LDR write.
  2. Buffer not empty → pop the head.
  3. `w_en_alu` → direct ALU write.
  4. None of the above → idle, `rf_w_en`=0 next cycle.
- ALU ordering:
  - While the buffer is non-empty, or while LDR holds the port, an accepted ALU request is pushed to the tail.
  - ALU writes never bypass older parked writes.
- Full buffer:
  - Full and no LDR: pop and push happen in the same cycle; the count is unchanged.
  - Full and `w_en_ldr`=1: no pop is possible, so `sel_stall` = full & `w_en_ldr`.
  - While `sel_stall`=1 the ALU request is ignored and upstream presents it again next cycle.
- Program order: the pipeline guarantees a concurrent LDR write is older than every parked ALU write. Parked entries to the same address are therefore kept and retire later, overwriting the LDR value.
- Forwarding:
  - `fwd_hit`/`fwd_data` search the parked entries only.
  - On multiple matches the newest entry wins.
  - An entry popped this cycle still counts as parked for this cycle's lookup.
- Pointers:
  - Read and write pointers wrap modulo DEPTH.
  - Full/empty are derived from `pending_count`, never from pointer equality alone.

## Timing
- Reset: `rf_w_en`=0, `rf_w_addr`=0, `rf_w_data`=0, `pending_count`=0, pointers=0; `sel_stall`, `fwd_hit` and `fwd_data` evaluate to 0.
- Reset mid-operation discards all parked entries immediately; any write not yet presented on the `rf_w_*` register is lost.
- Latency from a winning request to `rf_w_*`: exactly 1 cycle.
- A parked entry reaches the port no earlier than the first cycle without `w_en_ldr` after every older entry has been popped.
- `sel_stall` depends on same-cycle `w_en_ldr` (combinational path to the pipeline stall logic). The path must stay free of any dependency on `w_en_alu`.
- Buffer state updates on the same edge as the `rf_w_*` register.

## Structure
- Package `rf_wb_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - `wb_entry_t` packed struct holding {addr, data}.
  - `wb_src_t` enum (IDLE, LDR, PEND, ALU) for the port-select decision.
- Sub-module `wb_pending_fifo`: DEPTH-entry circular buffer with push, pop, count and a newest-first address search.
- The top level holds the arbitration mux, the stall logic and the output register.

## Test plan
- LDR alone, r3=0xDEADBEEF → next cycle `rf_w_en`=1, `rf_w_addr`=3, `rf_w_data`=0xDEADBEEF; `pending_count`=0.
- LDR r1=0x11 and ALU r2=0x22 together, then idle → cycle+1 writes r1; cycle+2 writes r2; count goes 1→0.
- Two cycles of LDR+ALU (r4=0xA then r4=0xB, DEPTH=2), `fwd_addr`=4 → `fwd_hit`=1, `fwd_data`=0xB; then two idle cycles → r4=0xA retires, then r4=0xB retires, in that order.
- Buffer full plus LDR+ALU → `sel_stall`=1, count stays 2, ALU not pushed; next cycle with ALU held and no LDR → head popped, ALU pushed, count=2, `sel_stall`=0.
- Parked entry with ALU valid and no LDR → the head is popped and the new ALU write is pushed; the new write does not go to the port directly.
- `rst_n` asserted with count=2 → all outputs 0 asynchronously; after release, an idle cycle gives `rf_w_en`=0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, entry layout and port-select encoding for the
// register-file writeback arbiter.
package rf_wb_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {IDLE, LDR, PEND, ALU} wb_src_t;
endpackage

// File: rtl/wb_pending_fifo.sv
// wb_pending_fifo: in-order circular buffer of parked ALU writes with a
// newest-first address search over the occupied entries.
module wb_pending_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W,
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] search_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end

    always_ff @(posedge clk)
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Scan oldest to newest so the last match (newest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && addr_mem[rd_ptr + PW'(i)] == search_addr) begin
                hit      = 1'b1;
                hit_data = data_mem[rd_ptr + PW'(i)];
            end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between LDR and
// ALU writeback; ALU writes that lose the port are parked in order.
module regfile_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W,
    parameter int DATA_W = rf_wb_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_en_ldr,
    input  logic [ADDR_W-1:0]        ldr_addr,
    input  logic [DATA_W-1:0]        ldr_data,
    input  logic                     w_en_alu,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     rf_w_en,
    output logic [ADDR_W-1:0]        rf_w_addr,
    output logic [DATA_W-1:0]        rf_w_data,
    output logic                     sel_stall,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   pending_count
);
    import rf_wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              push, pop, full, empty;
    wb_src_t           src;

    assign full  = pending_count == CW'(DEPTH);
    assign empty = pending_count == '0;
    // Stall must not depend on w_en_alu: it feeds the pipeline's own hold logic.
    assign sel_stall = full & w_en_ldr;
    assign pop       = !w_en_ldr & !empty;
    assign push      = w_en_alu & !sel_stall & (w_en_ldr | !empty);

    always_comb src = w_en_ldr ? LDR : !empty ? PEND : w_en_alu ? ALU : IDLE;

    wb_pending_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CW(CW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_addr  (alu_addr),
        .push_data  (alu_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (pending_count),
        .search_addr(fwd_addr),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rf_w_en   <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
        end else begin
            rf_w_en   <= src != IDLE;
            rf_w_addr <= src == LDR ? ldr_addr : src == PEND ? head_addr : alu_addr;
            rf_w_data <= src == LDR ? ldr_data : src == PEND ? head_data : alu_data;
        end
endmodule
